// File: rtl/mips_memory_arbiter_if.sv
// Bundle of requester-side handshakes and the mips_memory control/data bus
// seen by mips_memory_arbiter.
interface mips_memory_arbiter_if;
  logic        req0_valid;
  logic        req0_write;
  logic [1:0]  req0_store_control;
  logic [31:0] req0_address;
  logic [31:0] req0_write_data;
  logic        req1_valid;
  logic        req1_write;
  logic [1:0]  req1_store_control;
  logic [31:0] req1_address;
  logic [31:0] req1_write_data;
  logic        req0_ready;
  logic        req1_ready;
  logic        resp0_valid;
  logic        resp1_valid;
  logic [31:0] resp_read_data;
  logic        signal_mem_read;
  logic        signal_mem_write;
  logic [1:0]  signal_store_control;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req0_valid, req0_write, req0_store_control, req0_address, req0_write_data,
    input  req1_valid, req1_write, req1_store_control, req1_address, req1_write_data,
    input  mem_read_data,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_read_data,
    output signal_mem_read, signal_mem_write, signal_store_control,
    output mem_address, mem_write_data
  );

  modport master (
    output req0_valid, req0_write, req0_store_control, req0_address, req0_write_data,
    output req1_valid, req1_write, req1_store_control, req1_address, req1_write_data,
    output mem_read_data,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_read_data,
    input  signal_mem_read, signal_mem_write, signal_store_control,
    input  mem_address, mem_write_data
  );
endinterface

// File: rtl/mips_memory_arbiter.sv
// Round-robin two-requester front end for the single-port mips_memory:
// grant in IDLE, one-cycle memory strobe in ACCESS, response pulse in DONE.
module mips_memory_arbiter (
  input  logic                  clk,
  input  logic                  reset,
  mips_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_owner;
  logic        r_write;
  logic [1:0]  r_store_control;
  logic [31:0] r_address;
  logic [31:0] r_write_data;
  logic [31:0] r_read_data;
  logic        w_grant;
  logic        w_grant_id;

  // Winner on a tie is the requester that did not win last time.
  always_comb begin
    w_grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) w_grant_id = ~r_last_grant;
    else if (bus.req1_valid)              w_grant_id = 1'b1;
    w_grant = (r_state == S_IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (w_grant) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant    <= 1'b1;
      r_owner         <= 1'b0;
      r_write         <= 1'b0;
      r_store_control <= '0;
      r_address       <= '0;
      r_write_data    <= '0;
      r_read_data     <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_grant_id;
        r_owner      <= w_grant_id;
        if (w_grant_id) begin
          r_write         <= bus.req1_write;
          r_store_control <= bus.req1_store_control;
          r_address       <= bus.req1_address;
          r_write_data    <= bus.req1_write_data;
        end else begin
          r_write         <= bus.req0_write;
          r_store_control <= bus.req0_store_control;
          r_address       <= bus.req0_address;
          r_write_data    <= bus.req0_write_data;
        end
      end
      if (r_state == S_ACCESS && !r_write) r_read_data <= bus.mem_read_data;
    end
  end

  // Strobes are gated by reset so a reset landing in ACCESS drops the access.
  always_comb begin
    bus.req0_ready           = w_grant && !w_grant_id;
    bus.req1_ready           = w_grant && w_grant_id;
    bus.signal_mem_read      = (r_state == S_ACCESS) && !r_write && !reset;
    bus.signal_mem_write     = (r_state == S_ACCESS) && r_write && !reset;
    bus.resp0_valid          = (r_state == S_DONE) && !r_owner;
    bus.resp1_valid          = (r_state == S_DONE) && r_owner;
    bus.resp_read_data       = r_read_data;
    bus.signal_store_control = r_store_control;
    bus.mem_address          = r_address;
    bus.mem_write_data       = r_write_data;
  end

endmodule

// File: tb/tb_mips_memory_arbiter.sv
// Self-checking bench for mips_memory_arbiter: directed table, corner sequences,
// then random two-requester traffic against a transaction-level reference model.
module tb_mips_memory_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_memory_arbiter_if bus ();
  mips_memory_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] env_mem [0:127];
  logic [31:0] ref_mem [0:127];
  assign bus.mem_read_data = env_mem[bus.mem_address[8:2]];
  always @(posedge clk) if (bus.signal_mem_write) env_mem[bus.mem_address[8:2]] <= bus.mem_write_data;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] last_rd = '0;

  typedef struct {
    bit          req;
    bit          wr;
    logic [1:0]  sc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [0:5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_req(input bit n, input bit v, input bit wr, input logic [1:0] sc,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (n) begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_store_control = sc;
      bus.req1_address = addr; bus.req1_write_data = wd;
    end else begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_store_control = sc;
      bus.req0_address = addr; bus.req0_write_data = wd;
    end
  endtask

  // Entered just after a negedge in IDLE with the winner's request already driven.
  task automatic run_txn(input string nm, input bit own, input bit wr, input logic [1:0] sc,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit drop);
    #1;
    chk({nm, ".ready0"}, 32'(bus.req0_ready), 32'(own == 1'b0));
    chk({nm, ".ready1"}, 32'(bus.req1_ready), 32'(own == 1'b1));
    @(negedge clk);
    if (drop) begin
      if (own) begin bus.req1_valid = 1'b0; bus.req1_address = $urandom; bus.req1_write_data = $urandom; end
      else     begin bus.req0_valid = 1'b0; bus.req0_address = $urandom; bus.req0_write_data = $urandom; end
    end
    #1;
    chk({nm, ".mem_read"}, 32'(bus.signal_mem_read), 32'(!wr));
    chk({nm, ".mem_write"}, 32'(bus.signal_mem_write), 32'(wr));
    chk({nm, ".store_ctl"}, 32'(bus.signal_store_control), 32'(sc));
    chk({nm, ".address"}, bus.mem_address, addr);
    if (wr) chk({nm, ".wdata"}, bus.mem_write_data, wd);
    chk({nm, ".ready_access"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(negedge clk); #1;
    chk({nm, ".resp0"}, 32'(bus.resp0_valid), 32'(own == 1'b0));
    chk({nm, ".resp1"}, 32'(bus.resp1_valid), 32'(own == 1'b1));
    chk({nm, ".rdata"}, bus.resp_read_data, exp_rd);
    chk({nm, ".strobe_done"}, 32'({bus.signal_mem_read, bus.signal_mem_write}), 32'd0);
    chk({nm, ".ready_done"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(negedge clk);
  endtask

  // Random-phase reference state
  bit          pend [0:1];
  bit          p_wr [0:1];
  logic [1:0]  p_sc [0:1];
  logic [31:0] p_addr [0:1];
  logic [31:0] p_wd [0:1];

  initial begin
    for (int i = 0; i < 128; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
    tbl[0] = '{1'b0, 1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0,         32'hFFFF_FFFF};
    tbl[2] = '{1'b1, 1'b1, 2'b01, 32'h1, 32'h0000_00AB, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 2'b10, 32'h2, 32'h0000_CDEF, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 2'b00, 32'h8, 32'h0,         32'h1234_5678};
    tbl[5] = '{1'b0, 1'b1, 2'b00, 32'h4, 32'h1111_1111, 32'h0};

    // Reset held two cycles with both requesters valid
    set_req(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b1, 2'b00, 32'h8, 32'h1234_5678);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("reset.ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      chk("reset.resp", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
      chk("reset.strobe", 32'({bus.signal_mem_read, bus.signal_mem_write}), 32'd0);
      chk("reset.rdata", bus.resp_read_data, 32'h0);
    end
    reset = 1'b0;

    // Tie from reset release: alternating grants starting with requester 0
    run_txn("tie0", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    run_txn("tie1", 1'b1, 1'b1, 2'b00, 32'h8, 32'h1234_5678, 32'h0, 1'b0);
    run_txn("tie2", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    run_txn("tie3", 1'b1, 1'b1, 2'b00, 32'h8, 32'h1234_5678, 32'h0, 1'b0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    last_rd = 32'h0;

    // Directed single-requester vectors
    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].req, 1'b1, tbl[i].wr, tbl[i].sc, tbl[i].addr, tbl[i].wd);
      set_req(!tbl[i].req, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      run_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].wr, tbl[i].sc, tbl[i].addr,
              tbl[i].wd, tbl[i].wr ? last_rd : tbl[i].exp_rd, 1'b1);
      if (!tbl[i].wr) last_rd = tbl[i].exp_rd;
    end

    // Reset during ACCESS of a store drops it
    set_req(1'b0, 1'b1, 1'b1, 2'b00, 32'h4, 32'hA5A5_A5A5);
    #1 chk("rstmid.ready0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1; bus.req0_valid = 1'b0;
    #1;
    chk("rstmid.mem_write", 32'(bus.signal_mem_write), 32'd0);
    @(negedge clk); #1;
    chk("rstmid.resp", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
    chk("rstmid.rdata", bus.resp_read_data, 32'h0);
    reset = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 2'b00, 32'h4, 32'h0);
    run_txn("rstmid.load", 1'b0, 1'b0, 2'b00, 32'h4, 32'h0, 32'h1111_1111, 1'b1);

    // Late arrival: req1 raises valid during req0's ACCESS
    set_req(1'b0, 1'b1, 1'b0, 2'b00, 32'h4, 32'h0);
    #1 chk("late.ready0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 2'b00, 32'h8, 32'h0);
    #1 chk("late.ready1_access", 32'(bus.req1_ready), 32'd0);
    @(negedge clk); #1;
    chk("late.ready1_done", 32'(bus.req1_ready), 32'd0);
    chk("late.resp0", 32'(bus.resp0_valid), 32'd1);
    chk("late.rdata0", bus.resp_read_data, 32'h1111_1111);
    @(negedge clk);
    run_txn("late.req1", 1'b1, 1'b0, 2'b00, 32'h8, 32'h0, 32'h1234_5678, 1'b1);

    // Random traffic against a transaction-level model
    reset = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    begin
      bit          last = 1'b1;
      int          next_free = 0;
      int          g = -10;
      bit          t_own = 1'b0, t_wr = 1'b0;
      logic [1:0]  t_sc = '0;
      logic [31:0] t_addr = '0, t_wd = '0, t_rd = '0, exp_rd = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      for (int c = 0; c < 400; c++) begin
        bit granted, win;
        for (int n = 0; n < 2; n++) begin
          if (!pend[n] && $urandom_range(0, 2) == 0) begin
            pend[n] = 1'b1; p_wr[n] = 1'($urandom_range(0, 1)); p_sc[n] = 2'($urandom_range(0, 3));
            p_addr[n] = 32'h100 + 32'($urandom_range(0, 15) * 4); p_wd[n] = $urandom;
          end
          set_req(n[0], pend[n], p_wr[n], p_sc[n], p_addr[n], p_wd[n]);
        end
        #1;
        granted = (c >= next_free) && (pend[0] || pend[1]);
        win = (pend[0] && pend[1]) ? ~last : pend[1];
        if (granted) begin
          last = win; g = c; next_free = c + 3;
          t_own = win; t_wr = p_wr[win]; t_sc = p_sc[win]; t_addr = p_addr[win]; t_wd = p_wd[win];
          if (t_wr) ref_mem[t_addr[8:2]] = t_wd;
          else      t_rd = ref_mem[t_addr[8:2]];
        end
        chk("rnd.ready0", 32'(bus.req0_ready), 32'(granted && !win));
        chk("rnd.ready1", 32'(bus.req1_ready), 32'(granted && win));
        if (c == g + 1) begin
          chk("rnd.mem_read", 32'(bus.signal_mem_read), 32'(!t_wr));
          chk("rnd.mem_write", 32'(bus.signal_mem_write), 32'(t_wr));
          chk("rnd.address", bus.mem_address, t_addr);
          chk("rnd.store_ctl", 32'(bus.signal_store_control), 32'(t_sc));
          if (t_wr) chk("rnd.wdata", bus.mem_write_data, t_wd);
        end else begin
          chk("rnd.strobe_idle", 32'({bus.signal_mem_read, bus.signal_mem_write}), 32'd0);
        end
        if (c == g + 2) begin
          if (!t_wr) exp_rd = t_rd;
          chk("rnd.resp0", 32'(bus.resp0_valid), 32'(!t_own));
          chk("rnd.resp1", 32'(bus.resp1_valid), 32'(t_own));
          chk("rnd.rdata", bus.resp_read_data, exp_rd);
        end else begin
          chk("rnd.resp_idle", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
        end
        if (granted) pend[win] = 1'b0;
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
